// File: rtl/mem_arbiter_if.sv
// I-cache, D-cache and main-memory request/response bundle shared by the arbiter and its neighbours.
// The slave modport is the arbiter's view; master is the view of the cache/memory side that drives it.
interface mem_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [DATA_W-1:0] i_readdata;
    logic              i_busywait;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [DATA_W-1:0] d_writedata;
    logic [DATA_W-1:0] d_readdata;
    logic              d_busywait;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;
    logic              mem_busywait;

    modport slave (
        input  i_read, i_address, d_read, d_write, d_address, d_writedata,
        input  mem_readdata, mem_busywait,
        output i_readdata, i_busywait, d_readdata, d_busywait,
        output mem_read, mem_write, mem_address, mem_writedata
    );

    modport master (
        output i_read, i_address, d_read, d_write, d_address, d_writedata,
        output mem_readdata, mem_busywait,
        input  i_readdata, i_busywait, d_readdata, d_busywait,
        input  mem_read, mem_write, mem_address, mem_writedata
    );
endinterface

// File: rtl/mem_arbiter.sv
// I/D-cache to main-memory arbiter: one cycle of grant latency, completion once memory drops busywait after the first serve cycle; waiting requesters see busywait=1.
// Ties go to D (fixed priority) by default, or alternate against last_grant when MEM_ARB_RR_EN is defined.
module mem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic         CLK,
    input  logic         RESET,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_e;
    typedef enum logic {GRANT_I, GRANT_D} grant_e;

    state_e state_q, state_d;
    logic   issued_q, issued_d;
    grant_e last_grant_q, last_grant_d;

    logic              i_req, d_req, mem_ready;
    logic              i_done, d_done;
    logic              mem_read_c, mem_write_c;
    logic [ADDR_W-1:0] mem_address_c;
    logic [DATA_W-1:0] mem_writedata_c;
    state_e            tie_state;

    assign i_req     = bus.i_read;
    assign d_req     = bus.d_read | bus.d_write;
    // The first serve cycle never completes: memory has not yet seen the request.
    assign mem_ready = issued_q & ~bus.mem_busywait;

`ifdef MEM_ARB_RR_EN
    assign tie_state = (last_grant_q == GRANT_I) ? SERVE_D : SERVE_I;
`else
    assign tie_state = SERVE_D;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            issued_q     <= 1'b0;
            last_grant_q <= GRANT_I;
        end else begin
            state_q      <= state_d;
            issued_q     <= issued_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        issued_d        = 1'b0;
        last_grant_d    = last_grant_q;
        i_done          = 1'b0;
        d_done          = 1'b0;
        mem_read_c      = 1'b0;
        mem_write_c     = 1'b0;
        mem_address_c   = '0;
        mem_writedata_c = '0;
        case (state_q)
            IDLE: begin
                if (i_req && d_req) state_d = tie_state;
                else if (d_req)     state_d = SERVE_D;
                else if (i_req)     state_d = SERVE_I;
            end
            SERVE_I: begin
                mem_read_c    = bus.i_read;
                mem_address_c = bus.i_address;
                if (!i_req) begin
                    state_d = IDLE;
                end else if (mem_ready) begin
                    i_done       = 1'b1;
                    state_d      = IDLE;
                    last_grant_d = GRANT_I;
                end else begin
                    issued_d = 1'b1;
                end
            end
            SERVE_D: begin
                // A simultaneous read+write is carried out as a write.
                mem_read_c      = bus.d_read & ~bus.d_write;
                mem_write_c     = bus.d_write;
                mem_address_c   = bus.d_address;
                mem_writedata_c = bus.d_writedata;
                if (!d_req) begin
                    state_d = IDLE;
                end else if (mem_ready) begin
                    d_done       = 1'b1;
                    state_d      = IDLE;
                    last_grant_d = GRANT_D;
                end else begin
                    issued_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_read      = mem_read_c;
    assign bus.mem_write     = mem_write_c;
    assign bus.mem_address   = mem_address_c;
    assign bus.mem_writedata = mem_writedata_c;
    assign bus.i_readdata    = bus.mem_readdata;
    assign bus.d_readdata    = bus.mem_readdata;
    assign bus.i_busywait    = i_req & ~i_done;
    assign bus.d_busywait    = d_req & ~d_done;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a per-cycle ownership model.
`timescale 1ns/1ps
module tb_mem_arbiter;
    typedef logic [105:0] vec_t;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    mem_arbiter_if #(.ADDR_W(6), .DATA_W(32)) bus();
    mem_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

    int vectors = 0;
    int miscompares = 0;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    // Main memory: busy for mem_lat cycles of a continuous request, then ready.
    int mem_cnt = 0;
    int mem_lat = 0;
    always @(posedge CLK) mem_cnt <= (bus.mem_read || bus.mem_write) ? mem_cnt + 1 : 0;
    assign bus.mem_busywait = (bus.mem_read || bus.mem_write) && (mem_cnt < mem_lat);

    // Reference: who owns memory (0 none, 1 I, 2 D), cycles spent serving, last completed owner.
    int owner = 0;
    int age = 0;
    int last = 1;

    function automatic vec_t exp_vec();
        logic dreq, comp, mr, mw;
        logic [5:0] ma;
        logic [31:0] mwd;
        dreq = bus.d_read | bus.d_write;
        comp = (owner != 0) && (age >= 1) && !bus.mem_busywait;
        mr = 1'b0; mw = 1'b0; ma = '0; mwd = '0;
        if (owner == 1) begin
            mr = bus.i_read; ma = bus.i_address;
        end else if (owner == 2) begin
            mr = bus.d_read & ~bus.d_write; mw = bus.d_write;
            ma = bus.d_address; mwd = bus.d_writedata;
        end
        return {mr, mw, ma, mwd, bus.i_read && !(owner == 1 && comp), dreq && !(owner == 2 && comp),
                bus.mem_readdata, bus.mem_readdata};
    endfunction

    function automatic vec_t dut_vec();
        return {bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_writedata, bus.i_busywait,
                bus.d_busywait, bus.i_readdata, bus.d_readdata};
    endfunction

    task automatic model_edge();
        logic dreq, comp;
        dreq = bus.d_read | bus.d_write;
        comp = (owner != 0) && (age >= 1) && !bus.mem_busywait;
        if (RESET) begin
            owner = 0; age = 0; last = 1;
        end else if (owner == 0) begin
            age = 0;
            if (bus.i_read && dreq) owner = (RR && last == 2) ? 1 : 2;
            else if (dreq)          owner = 2;
            else if (bus.i_read)    owner = 1;
        end else if (!((owner == 1) ? bus.i_read : dreq)) begin
            owner = 0;
        end else if (comp) begin
            last = owner; owner = 0;
        end else begin
            age++;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_read = 1'b0; bus.i_address = '0;
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_writedata = '0;
        bus.mem_readdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        RESET = 1'b1;
        tick(); tick();
        RESET = 1'b0;
        @(negedge CLK);
        vectors++;
        if ({bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_writedata, bus.i_busywait, bus.d_busywait} !== 42'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0", {bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_writedata, bus.i_busywait, bus.d_busywait});
        end
        bus.i_read = 1'b1; bus.i_address = 6'h11;
        #1;
        vectors++;
        if ({bus.mem_read, bus.i_busywait} !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_idle_request: got %b want 01", {bus.mem_read, bus.i_busywait});
        end
        bus.i_read = 1'b0;
        tick();
    endtask

    task automatic test_i_read();
        int done_at = -1;
        mem_lat = 4; bus.mem_readdata = 32'hDEADBEEF;
        bus.i_read = 1'b1; bus.i_address = 6'h05;
        for (int c = 0; c < 20 && done_at < 0; c++) begin
            @(negedge CLK);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++; $display("FAIL model_i_read c=%0d: got %h want %h", c, dut_vec(), exp_vec());
            end
            if (c == 1) begin
                vectors++;
                if ({bus.mem_read, bus.mem_address} !== {1'b1, 6'h05}) begin
                    miscompares++; $display("FAIL i_read_grant: got %b want 1000101", {bus.mem_read, bus.mem_address});
                end
            end
            if (bus.i_busywait === 1'b0) begin
                done_at = c;
                vectors++;
                if (bus.i_readdata !== 32'hDEADBEEF) begin
                    miscompares++; $display("FAIL i_readdata: got %h want deadbeef", bus.i_readdata);
                end
            end
            tick();
        end
        vectors++;
        if (done_at !== 5) begin
            miscompares++; $display("FAIL i_read_latency: got %0d want 5", done_at);
        end
        bus.i_read = 1'b0;
        @(negedge CLK);
        vectors++;
        if ({bus.mem_read, bus.mem_address, bus.i_busywait} !== 8'h0) begin
            miscompares++; $display("FAIL i_read_idle_after: got %h want 0", {bus.mem_read, bus.mem_address, bus.i_busywait});
        end
        tick();
    endtask

    task automatic test_d_write();
        int done_at = -1;
        mem_lat = 2; bus.mem_readdata = $urandom;
        bus.d_write = 1'b1; bus.d_address = 6'h2A; bus.d_writedata = 32'h12345678;
        for (int c = 0; c < 20 && done_at < 0; c++) begin
            @(negedge CLK);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++; $display("FAIL model_d_write c=%0d: got %h want %h", c, dut_vec(), exp_vec());
            end
            if (c >= 1) begin
                vectors++;
                if ({bus.mem_write, bus.mem_read, bus.mem_address, bus.mem_writedata, bus.i_busywait} !== {2'b10, 6'h2A, 32'h12345678, 1'b0}) begin
                    miscompares++; $display("FAIL d_write_bus c=%0d: got %h", c, {bus.mem_write, bus.mem_read, bus.mem_address, bus.mem_writedata, bus.i_busywait});
                end
            end
            if (bus.d_busywait === 1'b0) done_at = c;
            tick();
        end
        vectors++;
        if (done_at !== 3) begin
            miscompares++; $display("FAIL d_write_latency: got %0d want 3", done_at);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_rw();
        int done_at = -1;
        mem_lat = 1;
        bus.d_read = 1'b1; bus.d_write = 1'b1; bus.d_address = 6'h3F; bus.d_writedata = 32'hA5A5_0F0F;
        for (int c = 0; c < 10 && done_at < 0; c++) begin
            @(negedge CLK);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++; $display("FAIL model_rw c=%0d: got %h want %h", c, dut_vec(), exp_vec());
            end
            if (c == 1) begin
                vectors++;
                if ({bus.mem_read, bus.mem_write} !== 2'b01) begin
                    miscompares++; $display("FAIL rw_as_write: got %b want 01", {bus.mem_read, bus.mem_write});
                end
            end
            if (bus.d_busywait === 1'b0) done_at = c;
            tick();
        end
        vectors++;
        if (done_at !== 2) begin
            miscompares++; $display("FAIL rw_latency: got %0d want 2", done_at);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_tie();
        int log_q[$];
        int d_t = -1;
        int i_t = -1;
        int exp_b[3];
        logic i_cmp, d_cmp;
        exp_b = RR ? '{2, 1, 2} : '{2, 2, 2};
        idle_inputs();
        RESET = 1'b1; tick(); RESET = 1'b0;
        mem_lat = 1;
        bus.i_read = 1'b1; bus.i_address = 6'h0C; bus.d_read = 1'b1; bus.d_address = 6'h30;
        for (int c = 0; c < 30 && (bus.i_read || bus.d_read); c++) begin
            @(negedge CLK);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++; $display("FAIL model_tie c=%0d: got %h want %h", c, dut_vec(), exp_vec());
            end
            i_cmp = bus.i_read && !bus.i_busywait;
            d_cmp = bus.d_read && !bus.d_busywait;
            if (d_cmp) begin log_q.push_back(2); d_t = c; end
            if (i_cmp) begin log_q.push_back(1); i_t = c; end
            tick();
            if (d_cmp) bus.d_read = 1'b0;
            if (i_cmp) bus.i_read = 1'b0;
        end
        vectors++;
        if (log_q.size() != 2 || log_q[0] != 2 || log_q[1] != 1) begin
            miscompares++; $display("FAIL tie_first_order: got %0d completions want D then I", log_q.size());
        end
        vectors++;
        if (i_t - d_t !== 3) begin
            miscompares++; $display("FAIL tie_idle_gap: got %0d want 3", i_t - d_t);
        end
        log_q.delete();
        bus.i_read = 1'b1; bus.d_read = 1'b1;
        for (int c = 0; c < 40 && log_q.size() < 3; c++) begin
            @(negedge CLK);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++; $display("FAIL model_tie_held c=%0d: got %h want %h", c, dut_vec(), exp_vec());
            end
            if (bus.d_read && !bus.d_busywait) log_q.push_back(2);
            if (bus.i_read && !bus.i_busywait) log_q.push_back(1);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (k >= log_q.size() || log_q[k] !== exp_b[k]) begin
                miscompares++; $display("FAIL tie_round_%0d: got %0d want %0d", k, (k < log_q.size()) ? log_q[k] : -1, exp_b[k]);
            end
        end
        idle_inputs();
        tick(); tick();
    endtask

    task automatic test_abort_reset();
        int first = 0;
        logic d_cmp;
        mem_lat = 5; bus.d_read = 1'b1; bus.d_address = 6'h10;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) bus.d_read = 1'b0;
            @(negedge CLK);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++; $display("FAIL model_abort c=%0d: got %h want %h", c, dut_vec(), exp_vec());
            end
            if (c == 2) begin
                vectors++;
                if (bus.mem_read !== 1'b0) begin
                    miscompares++; $display("FAIL abort_mem_read: got %b want 0", bus.mem_read);
                end
            end
            if (c == 3) begin
                vectors++;
                if ({bus.mem_read, bus.mem_address, bus.d_busywait} !== 8'h0) begin
                    miscompares++; $display("FAIL abort_idle: got %h want 0", {bus.mem_read, bus.mem_address, bus.d_busywait});
                end
            end
            tick();
        end
        // Leave last_grant at D so a correct reset is visible on the next tie.
        mem_lat = 0; bus.d_read = 1'b1;
        for (int c = 0; c < 6 && bus.d_read; c++) begin
            @(negedge CLK);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++; $display("FAIL model_d_setup c=%0d: got %h want %h", c, dut_vec(), exp_vec());
            end
            d_cmp = bus.d_read && !bus.d_busywait;
            tick();
            if (d_cmp) bus.d_read = 1'b0;
        end
        mem_lat = 5; bus.i_read = 1'b1; bus.i_address = 6'h21;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) RESET = 1'b1;
            @(negedge CLK);
            vectors++;
            if (bus.i_busywait !== 1'b1) begin
                miscompares++; $display("FAIL reset_no_completion c=%0d: got %b want 1", c, bus.i_busywait);
            end
            tick();
        end
        RESET = 1'b0;
        @(negedge CLK);
        vectors++;
        if ({bus.mem_read, bus.i_busywait} !== 2'b01) begin
            miscompares++; $display("FAIL reset_mid_serve_idle: got %b want 01", {bus.mem_read, bus.i_busywait});
        end
        bus.i_read = 1'b0;
        tick();
        mem_lat = 0; bus.i_read = 1'b1; bus.d_read = 1'b1;
        for (int c = 0; c < 10 && first == 0; c++) begin
            @(negedge CLK);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++; $display("FAIL model_post_reset c=%0d: got %h want %h", c, dut_vec(), exp_vec());
            end
            if (bus.d_busywait === 1'b0) first = 2;
            else if (bus.i_busywait === 1'b0) first = 1;
            tick();
        end
        vectors++;
        if (first !== 2) begin
            miscompares++; $display("FAIL reset_last_grant: got first=%0d want 2", first);
        end
        idle_inputs();
        tick(); tick();
    endtask

    task automatic test_random();
        logic i_cmp, d_cmp;
        for (int blk = 0; blk < 3; blk++) begin
            mem_lat = $urandom_range(0, 3);
            for (int c = 0; c < 150; c++) begin
                bus.i_address = 6'($urandom); bus.d_address = 6'($urandom);
                bus.d_writedata = $urandom; bus.mem_readdata = $urandom;
                RESET = ($urandom_range(0, 99) == 0);
                @(negedge CLK);
                vectors++;
                if (dut_vec() !== exp_vec()) begin
                    miscompares++; $display("FAIL model_random b=%0d c=%0d: got %h want %h", blk, c, dut_vec(), exp_vec());
                end
                i_cmp = bus.i_read && !bus.i_busywait;
                d_cmp = (bus.d_read || bus.d_write) && !bus.d_busywait;
                tick();
                if (i_cmp)           bus.i_read = ($urandom_range(0, 1) == 1);
                else if (bus.i_read) bus.i_read = ($urandom_range(0, 99) < 93);
                else                 bus.i_read = ($urandom_range(0, 99) < 40);
                if (d_cmp || !(bus.d_read || bus.d_write)) begin
                    case ($urandom_range(0, 5))
                        0:       begin bus.d_read = 1'b1; bus.d_write = 1'b0; end
                        1:       begin bus.d_read = 1'b0; bus.d_write = 1'b1; end
                        2:       begin bus.d_read = 1'b1; bus.d_write = 1'b1; end
                        default: begin bus.d_read = 1'b0; bus.d_write = 1'b0; end
                    endcase
                end else if ($urandom_range(0, 99) < 7) begin
                    bus.d_read = 1'b0; bus.d_write = 1'b0;
                end
            end
        end
        RESET = 1'b0;
        idle_inputs();
        tick(); tick();
    endtask

    initial begin
        RESET = 1'b1;
        idle_inputs();
        test_reset();
        test_i_read();
        test_d_write();
        test_rw();
        test_tie();
        test_abort_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 6: block-address width.
REQ-002 Parameter DATA_W, default 32: memory block data width.
REQ-003 Ports: one clock, CLK; reset RESET, synchronous, active-high.
REQ-004 CLK  input  1  system clock; all state changes on the rising edge.
REQ-005 RESET  input  1  synchronous active-high reset.
REQ-006 i_read  input  1  instruction-cache read request; i_address  input  ADDR_W.
REQ-007 i_readdata  output  DATA_W  block returned to the instruction cache; i_busywait  output  1  stall to the instruction cache.
REQ-008 d_read, d_write  input  1 each  data-cache requests; d_address  input  ADDR_W; d_writedata  input  DATA_W.
REQ-009 d_readdata  output  DATA_W; d_busywait  output  1  stall to the data cache.
REQ-010 mem_read, mem_write  output  1 each; mem_address  output  ADDR_W; mem_writedata  output  DATA_W  main-memory request.
REQ-011 mem_readdata  input  DATA_W; mem_busywait  input  1  main-memory stall.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SERVE_I, SERVE_D.
REQ-013 A one-bit issued flag SHALL be 0 on entry to a SERVE state and 1 from the second SERVE cycle onward; the first SERVE cycle always counts as busy.
REQ-014 Completion cycle: state SERVE_X, issued=1 and mem_busywait=0.
REQ-015 In IDLE, mem_read, mem_write and all memory address/data outputs SHALL be 0.
REQ-016 In IDLE with a request, the FSM SHALL move to SERVE_I or SERVE_D on the next edge. One cycle of grant latency.
REQ-017 In SERVE_I: mem_read=i_read, mem_write=0, mem_address=i_address.
REQ-018 In SERVE_D: mem_read=d_read&~d_write, mem_write=d_write, mem_address=d_address, mem_writedata=d_writedata.
REQ-019 i_readdata and d_readdata SHALL both equal mem_readdata combinationally; they are valid only in the owner's completion cycle.
REQ-020 x_busywait SHALL be 1 whenever port X has a request asserted, except in port X's completion cycle, where it SHALL be 0.
REQ-021 x_busywait SHALL be 0 when port X has no request.
REQ-022 After a completion cycle, the FSM SHALL return to IDLE. At least one IDLE cycle separates consecutive grants.
REQ-023 If the granted requester drops its request before completion (abort), the FSM SHALL return to IDLE on the next edge and issue no further memory request for it.
REQ-024 If d_read and d_write are asserted together, the request SHALL be treated as a write.
REQ-025 The FSM SHALL record last_grant (I or D) on every completion.
REQ-026 Simultaneous I and D requests in IDLE SHALL be resolved per REQ-031/REQ-032.
REQ-027 A request arriving during another port's service SHALL wait; it SHALL never pre-empt.

Reset
REQ-028 While RESET=1 at an edge: state<=IDLE, issued<=0, last_grant<=I.
REQ-029 All memory outputs SHALL be 0 in the cycle after reset; busywaits follow REQ-020/REQ-021 from IDLE.
REQ-030 Reset mid-service SHALL abandon the transfer with no completion cycle; requesters must re-request.

Configuration
REQ-031 With MEM_ARB_RR_EN defined: on a tie, grant the port not equal to last_grant (round-robin).
REQ-032 Without MEM_ARB_RR_EN: on a tie, D always wins (fixed priority); last_grant is still maintained but unused.

Verification
REQ-033 Single I read: i_read=1, i_address=6'h05, memory busy 4 cycles, mem_readdata=32'hDEADBEEF -> SERVE_I one cycle after request; i_busywait=0 with i_readdata=32'hDEADBEEF in completion cycle; IDLE next.
REQ-034 D write: d_write=1, d_address=6'h2A, d_writedata=32'h12345678 -> mem_write=1 with those values through service; d_busywait released at completion; i_busywait=0 throughout.
REQ-035 Tie, fixed priority: i_read and d_read both asserted from reset -> D served first, I served after one IDLE cycle; repeated tie -> D first again.
REQ-036 Tie with MEM_ARB_RR_EN: three back-to-back tied rounds -> grant order D, I, D.
REQ-037 Abort and reset: d_read dropped in the 2nd SERVE_D cycle -> IDLE next edge with mem_read=0; RESET=1 mid SERVE_I -> IDLE, no completion, last_grant=I.
REQ-038 Read+write: d_read=d_write=1 -> mem_write=1, mem_read=0.
